// File: rtl/icache_refill_responder_if.sv
// ICache refill bundle: line request/response on one side, word-wide BRAM read port on the other.
interface icache_refill_responder_if #(
  parameter int WORD          = 32,
  parameter int LINE_WORDS    = 4,
  parameter int RAM_DEPTH_LOG = 10
) ();
  logic                       memory_valid;
  logic [WORD-1:0]            load_addr;
  logic                       memory_ready;
  logic [WORD*LINE_WORDS-1:0] data_from_mem;
  logic                       mem_en;
  logic [RAM_DEPTH_LOG-1:0]   mem_addr;
  logic [WORD-1:0]            mem_dout;

  // master: the ICache and memory around the responder; slave: the responder itself
  modport master (
    output memory_valid, load_addr, mem_dout,
    input  memory_ready, data_from_mem, mem_en, mem_addr
  );

  modport slave (
    input  memory_valid, load_addr, mem_dout,
    output memory_ready, data_from_mem, mem_en, mem_addr
  );
endinterface

// File: rtl/icache_refill_responder.sv
// Reads LINE_WORDS consecutive words from 1-cycle-latency BRAM and returns them as one line.
// Request sampled in IDLE; memory_ready pulses LINE_WORDS+2 cycles later; dropping memory_valid mid-refill aborts.
module icache_refill_responder #(
  parameter int WORD          = 32,
  parameter int LINE_WORDS    = 4,
  parameter int RAM_DEPTH_LOG = 10
) (
  input logic clk,
  input logic rst,
  icache_refill_responder_if.slave bus
);
  localparam int OFF = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, RESP} state_t;

  state_t                     state_q;
  logic [RAM_DEPTH_LOG-1:0]   base_q, base_d, mem_addr_q;
  logic [OFF-1:0]             issue_q, issue_d, cap_q;
  logic                       mem_en_q, cap_vld_q, ready_q;
  logic [WORD*LINE_WORDS-1:0] line_q;

  // Byte offset and word-in-line bits are dropped, so any address inside a line maps to its base.
  assign base_d  = {bus.load_addr[RAM_DEPTH_LOG+1:OFF+2], {OFF{1'b0}}};
  assign issue_d = issue_q + OFF'(1);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.load_addr[WORD-1:RAM_DEPTH_LOG+2], bus.load_addr[OFF+1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      mem_addr_q <= '0;
      issue_q    <= '0;
      cap_q      <= '0;
      mem_en_q   <= 1'b0;
      cap_vld_q  <= 1'b0;
      ready_q    <= 1'b0;
      line_q     <= '0;
    end else begin
      cap_vld_q <= mem_en_q;
      ready_q   <= 1'b0;

      if (cap_vld_q && (state_q == READ || state_q == DRAIN)) begin
        line_q[cap_q*WORD +: WORD] <= bus.mem_dout;
        cap_q                      <= cap_q + OFF'(1);
      end

      case (state_q)
        IDLE: begin
          if (bus.memory_valid) begin
            base_q     <= base_d;
            issue_q    <= '0;
            cap_q      <= '0;
            mem_en_q   <= 1'b1;
            mem_addr_q <= base_d;
            state_q    <= READ;
          end
        end
        READ: begin
          if (!bus.memory_valid) begin
            mem_en_q <= 1'b0;
            state_q  <= IDLE;
          end else if (issue_q == OFF'(LINE_WORDS-1)) begin
            mem_en_q <= 1'b0;
            state_q  <= DRAIN;
          end else begin
            // Base is line-aligned, so OR-ing in the offset never carries into the line index.
            issue_q    <= issue_d;
            mem_addr_q <= base_q | RAM_DEPTH_LOG'(issue_d);
          end
        end
        DRAIN: begin
          if (!bus.memory_valid) begin
            state_q <= IDLE;
          end else begin
            ready_q <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.memory_ready  = ready_q;
  assign bus.data_from_mem = line_q;
  assign bus.mem_en        = mem_en_q;
  assign bus.mem_addr      = mem_addr_q;
endmodule

// File: tb/tb_icache_refill_responder.sv
// Directed bench: a cycle-phase model of the refill protocol checks every cycle, plus literal spot checks.
module tb_icache_refill_responder;
  localparam int W = 32;
  localparam int L = 4;
  localparam int D = 10;

  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  logic [W-1:0] mem [1<<D];

  icache_refill_responder_if #(.WORD(W), .LINE_WORDS(L), .RAM_DEPTH_LOG(D)) bus ();

  icache_refill_responder #(.WORD(W), .LINE_WORDS(L), .RAM_DEPTH_LOG(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.mem_en) bus.mem_dout <= mem[bus.mem_addr];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase counts cycles since the accepted request (0 = idle).
  int           phase   = 0;
  int           m_base  = 0;
  bit           line_ok = 0;
  logic [127:0] last_line, exp_line;

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_rst_en",   bus.mem_en, 0);
      chk("m_rst_rdy",  bus.memory_ready, 0);
      chk("m_rst_addr", bus.mem_addr, 0);
      chk("m_rst_data", bus.data_from_mem, 0);
      phase     = 0;
      last_line = '0;
      line_ok   = 1;
    end else begin
      chk("m_en",  bus.mem_en, (phase >= 1 && phase <= L));
      chk("m_rdy", bus.memory_ready, (phase == L + 2));
      if (phase >= 1 && phase <= L) chk("m_addr", bus.mem_addr, m_base + phase - 1);
      if (phase == L + 2) begin
        for (int k = 0; k < L; k++) exp_line[k*W +: W] = mem[m_base + k];
        chk("m_line", bus.data_from_mem, exp_line);
        last_line = exp_line;
        line_ok   = 1;
      end else if (phase <= 1 && line_ok) begin
        chk("m_hold", bus.data_from_mem, last_line);
      end

      if (phase == 0) begin
        if (bus.memory_valid) begin
          m_base = ((int'(bus.load_addr) >> 2) & ~(L - 1)) & ((1 << D) - 1);
          phase  = 1;
        end
      end else if (phase <= L + 1) begin
        if (bus.memory_valid) phase = phase + 1;
        else begin
          phase   = 0;
          line_ok = 0;
        end
      end else begin
        phase = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the request cycle; returns one cycle after RESP (itself a possible request cycle).
  task automatic refill(input logic [31:0] a, input int base, input logic [127:0] line, input bit keep);
    bus.memory_valid = 1'b1;
    bus.load_addr    = a;
    step();
    for (int k = 0; k < L; k++) begin
      chk("rd_en",   bus.mem_en, 1);
      chk("rd_addr", bus.mem_addr, base + k);
      chk("rd_rdy",  bus.memory_ready, 0);
      step();
    end
    chk("drain_en",  bus.mem_en, 0);
    chk("drain_rdy", bus.memory_ready, 0);
    step();
    chk("resp_rdy",  bus.memory_ready, 1);
    chk("resp_line", bus.data_from_mem, line);
    bus.memory_valid = keep;
    step();
    chk("post_rdy",  bus.memory_ready, 0);
    chk("post_line", bus.data_from_mem, line);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << D); i++) mem[i] = 32'h1000 + i;
    bus.memory_valid = 1'b0;
    bus.load_addr    = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("reset_en",   bus.mem_en, 0);
    chk("reset_addr", bus.mem_addr, 0);
    chk("reset_rdy",  bus.memory_ready, 0);
    chk("reset_data", bus.data_from_mem, 0);
    #9 rst = 1'b1;
    step();

    refill(32'h10, 4, 128'h00001007_00001006_00001005_00001004, 1'b0);

    // Abort: memory_valid dropped in cycle 2
    bus.memory_valid = 1'b1;
    bus.load_addr    = 32'h10;
    step();
    step();
    bus.memory_valid = 1'b0;
    step();
    chk("abort_en", bus.mem_en, 0);
    for (int k = 0; k < 5; k++) begin
      chk("abort_rdy", bus.memory_ready, 0);
      step();
    end
    refill(32'h20, 8, 128'h0000100B_0000100A_00001009_00001008, 1'b0);

    refill(32'h1C, 4, 128'h00001007_00001006_00001005_00001004, 1'b0);

    // Back-to-back: valid held through RESP
    refill(32'h40, 16, 128'h00001013_00001012_00001011_00001010, 1'b1);
    refill(32'h40, 16, 128'h00001013_00001012_00001011_00001010, 1'b0);

    // Reset in cycle 3 of a refill
    bus.memory_valid = 1'b1;
    bus.load_addr    = 32'h80;
    step();
    step();
    step();
    rst = 1'b0;
    #1;
    chk("midrst_en",   bus.mem_en, 0);
    chk("midrst_addr", bus.mem_addr, 0);
    chk("midrst_rdy",  bus.memory_ready, 0);
    chk("midrst_data", bus.data_from_mem, 0);
    bus.memory_valid = 1'b0;
    #5 rst = 1'b1;
    step();
    refill(32'h0, 0, 128'h00001003_00001002_00001001_00001000, 1'b0);

    // Last line of memory
    refill(32'hFF0, 1020, 128'h000013FF_000013FE_000013FD_000013FC, 1'b0);

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/icache_refill_responder.md
# icache_refill_responder

Memory-side responder for the instruction cache refill interface. It accepts a line-refill request (`memory_valid` + `load_addr`) from the ICache, reads `LINE_WORDS` consecutive words from a word-wide synchronous instruction memory with 1-cycle read latency, assembles them into one cache line, and returns the line with a single-cycle `memory_ready` pulse. It sits between the ICache and the instruction BRAM in `CPU_top`, replacing the direct PC-indexed instruction memory connection.

## Interface
Parameters:
- `WORD`, 32, data word width in bits
- `LINE_WORDS`, 4, words per cache line; power of two, ≥2; line width = `WORD*LINE_WORDS`
- `RAM_DEPTH_LOG`, 10, log2 of memory depth in words

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `memory_valid`  in  1  ICache refill request; held high until `memory_ready` is seen
- `load_addr`  in  `WORD`  byte address of the missing line
- `memory_ready`  out  1  one-cycle pulse: `data_from_mem` holds the requested line
- `data_from_mem`  out  `WORD*LINE_WORDS`  assembled line; word k at bits [WORD*k+WORD-1 : WORD*k]
- `mem_en`  out  1  memory read enable
- `mem_addr`  out  `RAM_DEPTH_LOG`  memory word index
- `mem_dout`  in  `WORD`  memory read data, valid the cycle after `mem_en`

## Operation
- FSM states: IDLE, READ, DRAIN, RESP.
- IDLE: `memory_valid`=1 at the clock edge → latch base = `load_addr[RAM_DEPTH_LOG+1:2]` with low log2(`LINE_WORDS`) bits forced to 0; clear issue and capture counters; go to READ. Low address bits (byte offset and word-in-line) are ignored.
- READ: `mem_en`=1, `mem_addr` = base + issue_cnt; issue_cnt increments each cycle. After issuing word `LINE_WORDS-1` → DRAIN.
- Capture: one-cycle-delayed copy of `mem_en` (cap_valid) writes `mem_dout` into line slot cap_cnt, then cap_cnt increments. Captures occur in READ (from 2nd cycle) and DRAIN.
- DRAIN: `mem_en`=0; capture last word; → RESP.
- RESP: `memory_ready`=1 for exactly one cycle; `memory_valid` is ignored in this state; → IDLE.
- Abort: `memory_valid`=0 in READ or DRAIN → IDLE on the next edge; in-flight read discarded; no `memory_ready`; `data_from_mem` may hold partial data and is not valid.
- `data_from_mem` is registered and holds its value after RESP until overwritten by a later capture.
- Address arithmetic is within an aligned line, so `mem_addr` never wraps. The last line of memory (indices 2^RAM_DEPTH_LOG−LINE_WORDS … 2^RAM_DEPTH_LOG−1) is served normally.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE; `memory_ready`=0; `mem_en`=0; `mem_addr`=0; `data_from_mem`=0; counters=0. Reset asserted mid-refill aborts immediately; no response follows.
- Request sampled in cycle 0 (IDLE). `mem_en` is high in cycles 1..`LINE_WORDS`, with `mem_addr` = base+0 … base+`LINE_WORDS`−1. DRAIN is cycle `LINE_WORDS`+1. `memory_ready` is high in cycle `LINE_WORDS`+2 (cycle 6 for the default parameters).
- Back-to-back: if `memory_valid` is still high in the cycle after RESP, that cycle is an IDLE sample and starts a new refill. Minimum request-to-request spacing is `LINE_WORDS`+3 cycles.
- `memory_ready`, `mem_en` and `mem_addr` are decoded from registered state and counters only; there is no combinational path from `memory_valid`.

## Test plan
- Memory preloaded with mem[i]=0x1000+i; `load_addr`=0x10 held → `mem_addr` 4,5,6,7 in cycles 1–4; `memory_ready` pulses in cycle 6 only; `data_from_mem`=0x00001007_00001006_00001005_00001004.
- `load_addr`=0x1C (unaligned) → same reads and the same line as 0x10.
- Request 0x10, `memory_valid` dropped in cycle 2 → `mem_en`=0 from cycle 3; no `memory_ready`. A following request 0x20 → line {0x100B,0x100A,0x1009,0x1008} with the standard latency.
- `memory_valid` held high through RESP with `load_addr`=0x40 → second refill starts the cycle after RESP; `memory_ready` again exactly `LINE_WORDS`+2 cycles after that sample.
- `rst` pulsed low in cycle 3 of a refill → all outputs 0 immediately; no `memory_ready`. A new request after reset release completes normally.
- `load_addr`=0xFF0 (word 1020, last line) → `mem_addr` 1020–1023; correct line returned; no wrap to 0.
